// File: rtl/mod_counter_pkg.sv
// Shared encodings for the programmable modulo counter family.
package mod_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic MODE_CONT    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/mod_m_counter_prog.sv
// Run-time programmable modulo counter with up/down, clear, load and a
// one-shot start/busy/done handshake.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | after reset/clear; waits for continuous mode or a start pulse
// RUN     | counting; q advances on enabled edges
// DONE    | one-shot finished; q holds the start value until relaunch
module mod_m_counter_prog
    import mod_counter_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    input  logic         up,
    input  logic         mode,
    input  logic         start,
    input  logic [N-1:0] m,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         max_tick,
    output logic         busy,
    output logic         done
);

    localparam logic [N-1:0] ONE_N = N'(1);

    state_t       state;
    logic [N-1:0] m_reg;
    logic [N-1:0] term_val;
    logic         at_term;
    logic [N-1:0] load_val;
    logic         launch;

    // A modulus of zero wraps to all-ones, giving the full 2^N range.
    function automatic logic [N-1:0] start_val(input logic [N-1:0] mm, input logic dir_up);
        return dir_up ? '0 : (mm - ONE_N);
    endfunction

    always_comb begin
        term_val = up ? (m_reg - ONE_N) : '0;
        at_term  = (q == term_val);
        max_tick = (state == ST_RUN) && en && at_term;
        load_val = ((m_reg != '0) && (d >= m_reg)) ? (m_reg - ONE_N) : d;
        launch   = (mode == MODE_CONT) || start;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q     <= '0;
            m_reg <= '0;
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (clr) begin
            q     <= start_val(m_reg, up);
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (load) begin
            q <= load_val;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (launch) begin
                        m_reg <= m;
                        q     <= start_val(m, up);
                        state <= ST_RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (en) begin
                        if (!at_term) begin
                            q <= up ? (q + ONE_N) : (q - ONE_N);
                        end else if (mode == MODE_ONESHOT) begin
                            q     <= start_val(m_reg, up);
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            // New modulus is only adopted at the wrap.
                            m_reg <= m;
                            q     <= start_val(m, up);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_m_counter_prog.sv
// Directed self-checking bench for mod_m_counter_prog at N=4.
module tb_mod_m_counter_prog;

    logic       clk = 1'b0;
    logic       reset, en, clr, up, mode, start, load;
    logic [3:0] m, d, q;
    logic       max_tick, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    mod_m_counter_prog #(.N(4)) dut (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .up(up), .mode(mode),
        .start(start), .m(m), .load(load), .d(d), .q(q),
        .max_tick(max_tick), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between clock edges.
    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; clr = 1'b0; up = 1'b1; mode = 1'b0;
        start = 1'b0; load = 1'b0; m = 4'd10; d = 4'd0;
        tick();
        tick();
        n_cmp++;
        if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || max_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: q=%0d busy=%b done=%b max_tick=%b, want 0/0/0/0", q, busy, done, max_tick);
        end
        reset = 1'b0;
    endtask

    task automatic test_cont_up();
        logic [3:0] exp_q;
        tick();
        n_cmp++;
        if (q !== 4'd0 || busy !== 1'b1 || max_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL cont_up_first: q=%0d busy=%b tick=%b, want 0/1/0", q, busy, max_tick);
        end
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp_q = (i == 10) ? 4'd0 : 4'(i);
            n_cmp++;
            if (q !== exp_q || max_tick !== (exp_q == 4'd9)) begin
                n_bad++;
                $display("FAIL cont_up step %0d: q=%0d tick=%b, want q=%0d tick=%b", i, q, max_tick, exp_q, (exp_q == 4'd9));
            end
        end
    endtask

    task automatic test_m0_m1();
        m = 4'd0; up = 1'b1; mode = 1'b0; en = 1'b1;
        pulse_reset();
        tick();
        n_cmp++;
        if (q !== 4'd0 || max_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL m0_first: q=%0d tick=%b, want 0/0", q, max_tick);
        end
        for (int i = 1; i <= 15; i++) begin
            tick();
            n_cmp++;
            if (q !== 4'(i) || max_tick !== (i == 15)) begin
                n_bad++;
                $display("FAIL m0 step %0d: q=%0d tick=%b, want q=%0d tick=%b", i, q, max_tick, i, (i == 15));
            end
        end
        m = 4'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (q !== 4'd0 || max_tick !== 1'b1) begin
                n_bad++;
                $display("FAIL m1 step %0d: q=%0d tick=%b, want 0/1", i, q, max_tick);
            end
        end
    endtask

    task automatic test_cont_down();
        logic [3:0] seq1 [5] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        logic [3:0] seq2 [9] = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd2, 4'd1, 4'd0, 4'd2};
        m = 4'd5; up = 1'b0; mode = 1'b0; en = 1'b1;
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (q !== seq1[i] || max_tick !== (seq1[i] == 4'd0)) begin
                n_bad++;
                $display("FAIL down step %0d: q=%0d tick=%b, want q=%0d tick=%b", i, q, max_tick, seq1[i], (seq1[i] == 4'd0));
            end
        end
        // wrap to 4, then change modulus mid-count
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 0) m = 4'd3;
            n_cmp++;
            if (q !== seq2[i] || max_tick !== (seq2[i] == 4'd0)) begin
                n_bad++;
                $display("FAIL down_newm step %0d: q=%0d tick=%b, want q=%0d tick=%b", i, q, max_tick, seq2[i], (seq2[i] == 4'd0));
            end
        end
    endtask

    task automatic test_oneshot();
        // columns: en, start, exp q, exp busy, exp done, exp max_tick
        logic [3:0] vq   [12] = '{0, 0, 1, 1, 1, 2, 0, 0, 0, 1, 2, 0};
        logic       ven  [12] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        logic       vst  [12] = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        logic       vbsy [12] = '{0, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0};
        logic       vdn  [12] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1};
        logic       vmt  [12] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        m = 4'd3; up = 1'b1; mode = 1'b1; en = 1'b1; start = 1'b0;
        pulse_reset();
        for (int i = 0; i < 12; i++) begin
            en = ven[i];
            start = vst[i];
            tick();
            start = 1'b0;
            en = (i < 11) ? ven[i+1] : 1'b1;
            n_cmp++;
            if (q !== vq[i] || busy !== vbsy[i] || done !== vdn[i] || max_tick !== vmt[i]) begin
                n_bad++;
                $display("FAIL oneshot step %0d: q=%0d busy=%b done=%b tick=%b, want %0d/%b/%b/%b",
                         i, q, busy, done, max_tick, vq[i], vbsy[i], vdn[i], vmt[i]);
            end
        end
    endtask

    task automatic test_load_clr();
        m = 4'd10; up = 1'b1; mode = 1'b0; en = 1'b1;
        pulse_reset();
        tick();
        tick();
        load = 1'b1; d = 4'd12;
        tick();
        load = 1'b0;
        n_cmp++;
        if (q !== 4'd9 || max_tick !== 1'b1) begin
            n_bad++;
            $display("FAIL load_sat: q=%0d tick=%b, want 9/1", q, max_tick);
        end
        load = 1'b1; d = 4'd5;
        tick();
        load = 1'b0;
        n_cmp++;
        if (q !== 4'd5 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL load_plain: q=%0d busy=%b, want 5/1", q, busy);
        end
        load = 1'b1; clr = 1'b1; d = 4'd7;
        tick();
        load = 1'b0; clr = 1'b0;
        n_cmp++;
        if (q !== 4'd0 || busy !== 1'b0 || max_tick !== 1'b0) begin
            n_bad++;
            $display("FAIL load_clr: q=%0d busy=%b tick=%b, want 0/0/0", q, busy, max_tick);
        end
        tick();
        tick();
        n_cmp++;
        if (q !== 4'd1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_resume: q=%0d busy=%b, want 1/1", q, busy);
        end
    endtask

    task automatic test_async_reset();
        m = 4'd10; up = 1'b1; mode = 1'b0; en = 1'b1;
        pulse_reset();
        tick();
        for (int i = 0; i < 7; i++) tick();
        n_cmp++;
        if (q !== 4'd7) begin
            n_bad++;
            $display("FAIL pre_reset: q=%0d, want 7", q);
        end
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: q=%0d busy=%b done=%b, want 0/0/0", q, busy, done);
        end
        #1 reset = 1'b0;
        tick();
        n_cmp++;
        if (q !== 4'd0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_idle_cycle: q=%0d busy=%b, want 0/1", q, busy);
        end
        tick();
        n_cmp++;
        if (q !== 4'd1) begin
            n_bad++;
            $display("FAIL reset_resume: q=%0d, want 1", q);
        end
    endtask

    initial begin
        test_reset();
        test_cont_up();
        test_m0_m1();
        test_cont_down();
        test_oneshot();
        test_load_clr();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
